// File: rtl/cpu_step_pkg.sv
// Shared types for the CPU step controller: FSM states, default parameters
// and the press-priority rule applied when several buttons fire at once.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_RUN_DIV         = 50_000_000;
  localparam int DEF_RST_HOLD        = 4;
  localparam int DEF_CNT_W           = 16;

  // Press vector bit positions; a higher index outranks every lower one.
  localparam int PRESS_N   = 3;
  localparam int PRIO_STEP = 0;
  localparam int PRIO_RUN  = 1;
  localparam int PRIO_RST  = 2;

  typedef logic [PRESS_N-1:0] press_t;

  // Keep only the highest-ranked request; lower ones in the same cycle are dropped.
  function automatic press_t press_resolve(input press_t req);
    press_t win;
    win = '0;
    for (int i = 0; i < PRESS_N; i++) begin
      if (req[i]) begin
        win = press_t'(1) << i;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Button front end: 2-FF sync, stability debounce, registered rising-edge pulse.
// Latency raw edge -> press_vld: 2 + DEBOUNCE_CYCLES + 1 cycles; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press_vld
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          prev_q,  prev_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Counter only runs while the input disagrees; any agreeing cycle resets it.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    prev_d  = level_q;
    press_d = level_q & ~prev_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_vld = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Board-button front end for the CPU: HOLD/STEP/RUN mode FSM, one-cycle cpu_en,
// held cpu_reset and step counter; press -> output in 1 cycle, no backpressure.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RUN_DIV         = DEF_RUN_DIV,
  parameter int RST_HOLD        = DEF_RST_HOLD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             btn_rst,
  output logic             cpu_en,
  output logic             cpu_reset,
  output logic             run_mode,
  output logic [CNT_W-1:0] step_count
);

  localparam int DW = $clog2(RUN_DIV);
  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(RUN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  logic step_vld, run_vld, rst_vld;
  press_t press_req, press_win;

  state_e           state_q,     state_d;
  logic [HW-1:0]    hold_q,      hold_d;
  logic [DW-1:0]    div_q,       div_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             en_q,        en_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             run_mode_q,  run_mode_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (btn_step),
    .press_vld (step_vld)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (btn_run),
    .press_vld (run_vld)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (btn_rst),
    .press_vld (rst_vld)
  );

  always_comb begin
    press_req            = '0;
    press_req[PRIO_STEP] = step_vld;
    press_req[PRIO_RUN]  = run_vld;
    press_req[PRIO_RST]  = rst_vld;
    press_win            = press_resolve(press_req);

    state_d = state_q;
    hold_d  = hold_q;
    div_d   = div_q;
    en_d    = 1'b0;
    count_d = count_q;

    case (state_q)
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = STEP;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      STEP: begin
        if (press_win[PRIO_RUN]) begin
          state_d = RUN;
          div_d   = '0;
        end else if (press_win[PRIO_STEP]) begin
          en_d = 1'b1;
        end
      end
      RUN: begin
        if (press_win[PRIO_RUN]) begin
          state_d = STEP;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          en_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase

    // The reset press overrides whatever the current state decided.
    if (press_win[PRIO_RST]) begin
      state_d = HOLD;
      hold_d  = '0;
      div_d   = '0;
      en_d    = 1'b0;
      count_d = '0;
    end else if (en_d) begin
      count_d = count_q + 1'b1;
    end

    cpu_reset_d = (state_d == HOLD);
    run_mode_d  = (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= HOLD;
      hold_q      <= '0;
      div_q       <= '0;
      count_q     <= '0;
      en_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      run_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      div_q       <= div_d;
      count_q     <= count_d;
      en_q        <= en_d;
      cpu_reset_q <= cpu_reset_d;
      run_mode_q  <= run_mode_d;
    end
  end

  assign cpu_en     = en_q;
  assign cpu_reset  = cpu_reset_q;
  assign run_mode   = run_mode_q;
  assign step_count = count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus random button traffic,
// all outputs compared every cycle against a cycle-level reference model.
module tb_cpu_step_ctrl;

  localparam int DB    = 4;
  localparam int DIV   = 8;
  localparam int HOLDN = 4;
  localparam int CW    = 4;
  localparam logic [2:0] B_STEP = 3'b001;
  localparam logic [2:0] B_RUN  = 3'b010;
  localparam logic [2:0] B_RST  = 3'b100;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    btn_v = 3'b000;
  logic          cpu_en, cpu_reset, run_mode;
  logic [CW-1:0] step_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .RUN_DIV         (DIV),
    .RST_HOLD        (HOLDN),
    .CNT_W           (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_step   (btn_v[0]),
    .btn_run    (btn_v[1]),
    .btn_rst    (btn_v[2]),
    .cpu_en     (cpu_en),
    .cpu_reset  (cpu_reset),
    .run_mode   (run_mode),
    .step_count (step_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model. Buttons are indexed 0=step, 1=run, 2=rst; k counts edges
  // since reset release, and anything before edge 1 reads as 0.
  bit raw_h[3][16];
  bit lvl_h[3][16];
  int k, m_mode, m_hold, m_age, m_cnt;
  bit m_en;

  function automatic bit rh(input int b, input int j);
    if (j < 1) return 1'b0;
    return raw_h[b][j % 16];
  endfunction

  function automatic bit lh(input int b, input int j);
    if (j < 1) return 1'b0;
    return lvl_h[b][j % 16];
  endfunction

  task automatic model_step();
    bit [2:0] pr;
    bit flip;
    k++;
    for (int b = 0; b < 3; b++) begin
      raw_h[b][k % 16] = btn_v[b];
      // Level flips once the last DB synchronised samples (2 edges old) all disagree.
      flip = 1'b1;
      for (int i = 2; i <= DB + 1; i++)
        if (rh(b, k - i) == lh(b, k - 1)) flip = 1'b0;
      lvl_h[b][k % 16] = lh(b, k - 1) ^ flip;
      pr[b] = lh(b, k - 2) & ~lh(b, k - 3);
    end
    m_en = 1'b0;
    if (pr[2]) begin
      m_mode = 0; m_hold = HOLDN; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_hold--;
      if (m_hold == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (pr[1]) begin m_mode = 2; m_age = 0; end
      else if (pr[0]) m_en = 1'b1;
    end else begin
      if (pr[1]) m_mode = 1;
      else begin
        m_age++;
        if (m_age % DIV == 0) m_en = 1'b1;
      end
    end
    if (m_en) m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      k = 0; m_mode = 0; m_hold = HOLDN; m_age = 0; m_cnt = 0; m_en = 1'b0;
    end else begin
      model_step();
    end
    #1;
    chk("cpu_en",     int'(cpu_en),     int'(m_en));
    chk("cpu_reset",  int'(cpu_reset),  int'(m_mode == 0));
    chk("run_mode",   int'(run_mode),   int'(m_mode == 2));
    chk("step_count", int'(step_count), m_cnt);
    chk("en_while_rst", int'(cpu_en & cpu_reset), 0);
  end

  task automatic cyc(input logic [2:0] v);
    @(negedge clock);
    btn_v = v;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    btn_v = 3'b000;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (!cpu_reset) break;
    end
    chk("reset_exit", int'(cpu_reset), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_en"},   int'(cpu_en),     0);
    chk({tag, "_rst"},  int'(cpu_reset),  1);
    chk({tag, "_run"},  int'(run_mode),   0);
    chk({tag, "_cnt"},  int'(step_count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    int n, t1, t2, len[3];
    logic [2:0] v;

    // Reset state, then release: cpu_reset held for exactly RST_HOLD edges.
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("in_reset");
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      n++;
      if (!cpu_reset) break;
    end
    chk("rst_release_len", n, HOLDN);

    // Bounce then hold: a single enable, 7 edges after the held level is first sampled.
    cyc(B_STEP); cyc(3'b000); cyc(B_STEP); cyc(3'b000);
    n = 0; t1 = -1;
    for (int t = 0; t < 14; t++) begin
      cyc((t < 10) ? B_STEP : 3'b000);
      if (cpu_en) begin n++; t1 = t; end
    end
    chk("bounce_en_n", n, 1);
    chk("bounce_en_t", t1, 7);
    chk("bounce_cnt", int'(step_count), 1);

    // Run mode from a fresh STEP: enables 8 and 16 edges after entry, step ignored.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(B_RUN);
      if (run_mode) break;
    end
    chk("run_entry", int'(run_mode), 1);
    n = 0; t1 = -1; t2 = -1;
    for (int t = 1; t <= 20; t++) begin
      v = ((t < 4) ? B_RUN : 3'b000) | ((t >= 6 && t < 14) ? B_STEP : 3'b000);
      cyc(v);
      if (cpu_en) begin
        n++;
        if (t1 < 0) t1 = t; else t2 = t;
      end
    end
    chk("run_en_n", n, 2);
    chk("run_en_1st", t1, 8);
    chk("run_en_2nd", t2, 16);
    chk("run_cnt", int'(step_count), 2);

    // rst and run pressed together in RUN: rst wins, HOLD for RST_HOLD, then STEP.
    for (int i = 0; i < 20; i++) begin
      cyc(B_RST | B_RUN);
      if (cpu_reset) break;
    end
    chk("rr_hold_entry", int'(cpu_reset), 1);
    chk("rr_run_mode", int'(run_mode), 0);
    chk("rr_cnt", int'(step_count), 0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      cyc(B_RST | B_RUN);
      if (!cpu_reset) break;
      n++;
    end
    chk("rr_hold_len", n, HOLDN);
    chk("rr_in_step", int'(run_mode), 0);
    repeat (10) cyc(3'b000);

    // 17 step presses wrap the 4-bit counter to 1.
    do_reset();
    repeat (17) begin
      repeat (7) cyc(B_STEP);
      repeat (7) cyc(3'b000);
    end
    chk("wrap_cnt", int'(step_count), 1);

    // Async reset mid-RUN and mid-debounce: immediate reset values, no stray enable.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(B_RUN);
      if (run_mode) break;
    end
    repeat (3) cyc(3'b000);
    cyc(B_STEP);
    cyc(B_STEP);
    chk("mid_run", int'(run_mode), 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clock);
    btn_v = 3'b000;
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (cpu_en) n++;
    end
    chk("post_rst_en", n, 0);
    chk("post_rst_cnt", int'(step_count), 0);
    chk("post_rst_run", int'(run_mode), 0);

    // Random button traffic with occasional async resets; the model checks every cycle.
    len = '{0, 0, 0};
    v = 3'b000;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (len[b] == 0) begin
          v[b] = (b == 2) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
          len[b] = $urandom_range(1, 12);
        end
        len[b]--;
      end
      cyc(v);
      if ($urandom_range(0, 399) == 0) begin
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
      end
    end

    repeat (3) cyc(3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Board-input front end for the single-cycle CPU: the input-side counterpart of the seven-segment display path. It synchronises and debounces three push buttons, and runs a small mode FSM. The FSM produces a one-cycle CPU clock-enable, either one per step press or free-running at a divided rate, plus a held CPU reset and an executed-step counter for display. It sits between the board buttons and the CPU core at top level.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a new button level.
- RUN_DIV, 50_000_000: clock cycles between enables in run mode; must be ≥2.
- RST_HOLD, 4: cycles `cpu_reset` is held after any reset event; must be ≥1.
- CNT_W, 16: width of `step_count`.
- clock  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset.
- btn_step  input  1  raw step button, active-high, asynchronous to `clock`.
- btn_run  input  1  raw run/stop toggle button, active-high, asynchronous.
- btn_rst  input  1  raw CPU-reset button, active-high, asynchronous.
- cpu_en  output  1  one-cycle enable; the CPU advances one instruction per high cycle.
- cpu_reset  output  1  active-high reset to the CPU core.
- run_mode  output  1  1 while in RUN.
- step_count  output  CNT_W  number of `cpu_en` pulses since the last reset event; wraps.

## Operation
- Per button:
  - 2-FF synchroniser.
  - Debouncer: the debounced level flips only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - Registered rising-edge detector producing a one-cycle press pulse.
- FSM states: HOLD, STEP, RUN.
  - HOLD: `cpu_reset`=1, `cpu_en`=0. A hold counter counts RST_HOLD cycles, then the FSM moves to STEP.
  - STEP: a step press gives `cpu_en`=1 for exactly one cycle. A run press moves to RUN.
  - RUN: the divider counts 0..RUN_DIV-1, and `cpu_en` pulses on the terminal count. A run press moves to STEP. Step presses are ignored.
- An rst press in any state moves to HOLD, restarts the hold counter, clears `step_count`, and clears the divider.
- Simultaneous press pulses: rst > run > step. Lower-priority pulses in the same cycle are dropped.
- `step_count` increments in the cycle `cpu_en` is high and wraps from 2^CNT_W-1 to 0.
- The divider clears on every entry to RUN, so the first run enable comes RUN_DIV cycles after entry.
- A button held down produces exactly one press pulse; there is no auto-repeat.

## Timing
- Reset values:
  - `cpu_en`=0, `cpu_reset`=1, `run_mode`=0, `step_count`=0.
  - FSM in HOLD; all synchronisers, debounced levels and counters at 0.
- After `reset` deasserts, `cpu_reset` stays 1 for RST_HOLD cycles, then drops.
- Press pulse high in cycle N:
  - step press: `cpu_en` high in N+1.
  - run press: `run_mode` changes in N+1.
  - rst press: `cpu_reset` high from N+1.
- Raw edge to press pulse: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 edge-register cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `cpu_en` is never high while `cpu_reset` is high.
- Asynchronous reset mid-RUN or mid-debounce aborts everything immediately and returns all state to its reset values.

## Structure
- Package `cpu_step_pkg`:
  - state enum {HOLD, STEP, RUN};
  - default parameter constants;
  - the priority rule as documented constants.
- Sub-module `btn_debounce` (synchroniser + debouncer + edge detect, parameter DEBOUNCE_CYCLES), instantiated three times.
- The top holds the FSM, the hold counter, the divider and `step_count`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, RUN_DIV=8, RST_HOLD=4, CNT_W=4.
- Reset release -> `cpu_reset`=1 for exactly 4 cycles, then 0; `cpu_en` stays 0 and `step_count`=0 throughout.
- Bounce on btn_step (1,0,1,0 over 4 cycles), then held 1 for 10 cycles -> exactly one `cpu_en` pulse, 7 cycles after the held-1 start; `step_count`=1.
- In STEP, run press, then 20 cycles -> `run_mode`=1; `cpu_en` pulses 8 and 16 cycles after entry; `step_count`=2; step presses during RUN have no effect.
- 17 step presses from reset -> `step_count` reads 1 (wrap at 16).
- rst and run pulses in the same cycle while in RUN -> HOLD entered, `run_mode`=0, `step_count`=0, `cpu_reset`=1 for 4 cycles, then STEP.
- Async `reset` asserted mid-debounce and mid-RUN divider count -> all outputs return to reset values immediately, and no `cpu_en` is produced after release without a new press.
